// File: rtl/change_dispenser.sv
// Change/refund payout: greedy 10 / 1 / 0.5 yuan coins over an eject/ack hopper handshake.
// Define CHANGE_INV_EN to track per-denomination coin stock and fault on change shortfall.
module change_dispenser #(
    parameter int SUM_MAX = 40,
    parameter int ACK_TMO = 1000,
    parameter int INV_10  = 4,
    parameter int INV_1   = 20,
    parameter int INV_H   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       charge_ind,
    input  logic [5:0] coin_sum,
    input  logic       hopper_ack,
    output logic       eject,
    output logic [1:0] eject_type,
    output logic       busy,
    output logic       done,
    output logic [5:0] remaining,
    output logic       fault,
    output logic [2:0] inv_empty
);
    localparam int         TW       = $clog2(ACK_TMO + 1);
    localparam logic [1:0] C_NONE   = 2'b00;
    localparam logic [1:0] C_1      = 2'b01;
    localparam logic [1:0] C_10     = 2'b10;
    localparam logic [1:0] C_H      = 2'b11;
    localparam logic [6:0] SUM_MAX7 = 7'(SUM_MAX);

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, DONE, FAULT} state_t;

    state_t        state;
    logic          charge_q;
    logic          req;
    logic [TW-1:0] tmo_cnt;
    logic [5:0]    sum_clamped;
    logic [1:0]    pick;
    logic [5:0]    coin_val;
    logic          ok10, ok1, okh;

    assign req         = charge_ind & ~charge_q;
    assign sum_clamped = ({1'b0, coin_sum} > SUM_MAX7) ? SUM_MAX7[5:0] : coin_sum;

`ifdef CHANGE_INV_EN
    logic [7:0] stk10, stk1, stkh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk10 <= 8'(INV_10);
            stk1  <= 8'(INV_1);
            stkh  <= 8'(INV_H);
        end else if (state == EJECT && hopper_ack) begin
            case (eject_type)
                C_10:    stk10 <= stk10 - 8'd1;
                C_1:     stk1  <= stk1 - 8'd1;
                C_H:     stkh  <= stkh - 8'd1;
                default: ;
            endcase
        end
    end

    assign ok10      = (stk10 != 8'd0);
    assign ok1       = (stk1 != 8'd0);
    assign okh       = (stkh != 8'd0);
    assign inv_empty = {~okh, ~ok1, ~ok10};
`else
    logic unused_inv_cfg;

    assign ok10           = 1'b1;
    assign ok1            = 1'b1;
    assign okh            = 1'b1;
    assign inv_empty      = 3'b000;
    assign unused_inv_cfg = ^{INV_10, INV_1, INV_H};
`endif

    // Largest coin that fits the remainder and is in stock; C_NONE means shortfall.
    always_comb begin
        pick = C_NONE;
        if (remaining >= 6'd20 && ok10)
            pick = C_10;
        else if (remaining >= 6'd2 && ok1)
            pick = C_1;
        else if (remaining != 6'd0 && okh)
            pick = C_H;
    end

    always_comb begin
        coin_val = 6'd0;
        case (eject_type)
            C_10:    coin_val = 6'd20;
            C_1:     coin_val = 6'd2;
            C_H:     coin_val = 6'd1;
            default: coin_val = 6'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            charge_q   <= 1'b0;
            eject      <= 1'b0;
            eject_type <= C_NONE;
            busy       <= 1'b0;
            done       <= 1'b0;
            remaining  <= 6'd0;
            fault      <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            charge_q <= charge_ind;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        remaining <= sum_clamped;
                        busy      <= 1'b1;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (remaining == 6'd0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (pick == C_NONE) begin
                        busy  <= 1'b0;
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        eject      <= 1'b1;
                        eject_type <= pick;
                        tmo_cnt    <= '0;
                        state      <= EJECT;
                    end
                end
                EJECT: begin
                    if (hopper_ack) begin
                        remaining  <= remaining - coin_val;
                        eject      <= 1'b0;
                        eject_type <= C_NONE;
                        state      <= SELECT;
                    end else if (tmo_cnt == TW'(ACK_TMO - 1)) begin
                        eject      <= 1'b0;
                        eject_type <= C_NONE;
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                        state      <= FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FAULT: begin
                    eject <= 1'b0;
                    busy  <= 1'b0;
                    fault <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model queues expected coins and remainders.
module tb_change_dispenser;
    localparam int TMO  = 16;
    localparam int SMAX = 40;
`ifdef CHANGE_INV_EN
    localparam int I10 = 0;
    localparam int I1  = 20;
    localparam int IH  = 0;
    localparam int EXP_INV = ((IH == 0) ? 4 : 0) + ((I1 == 0) ? 2 : 0) + ((I10 == 0) ? 1 : 0);
`else
    localparam int I10 = 4;
    localparam int I1  = 20;
    localparam int IH  = 20;
    localparam int EXP_INV = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       charge_ind = 1'b0;
    logic [5:0] coin_sum = 6'd0;
    logic       hopper_ack = 1'b0;
    logic       eject;
    logic [1:0] eject_type;
    logic       busy;
    logic       done;
    logic [5:0] remaining;
    logic       fault;
    logic [2:0] inv_empty;

    int checks = 0;
    int failures = 0;
    int exp_type_q[$];
    int exp_rem_q[$];
    int m10, m1, mh;

    always #5 clk = ~clk;

    change_dispenser #(
        .SUM_MAX(SMAX), .ACK_TMO(TMO), .INV_10(I10), .INV_1(I1), .INV_H(IH)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .charge_ind(charge_ind), .coin_sum(coin_sum),
        .hopper_ack(hopper_ack), .eject(eject), .eject_type(eject_type), .busy(busy),
        .done(done), .remaining(remaining), .fault(fault), .inv_empty(inv_empty)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
`ifdef CHANGE_INV_EN
        m10 = I10; m1 = I1; mh = IH;
`else
        m10 = 1000000; m1 = 1000000; mh = 1000000;
`endif
        exp_type_q.delete();
        exp_rem_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        charge_ind = 1'b0;
        hopper_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Greedy payout model with stock skipping; type codes 1=1 yuan, 2=10 yuan, 3=0.5 yuan.
    task automatic plan(input int amt, output bit f, output int clamp);
        int r;
        f = 1'b0;
        r = (amt > SMAX) ? SMAX : amt;
        clamp = r;
        while (r > 0) begin
            if (r >= 20 && m10 > 0) begin
                exp_type_q.push_back(2); r -= 20; m10--;
            end else if (r >= 2 && m1 > 0) begin
                exp_type_q.push_back(1); r -= 2; m1--;
            end else if (mh > 0) begin
                exp_type_q.push_back(3); r -= 1; mh--;
            end else begin
                f = 1'b1;
                break;
            end
            exp_rem_q.push_back(r);
        end
    endtask

    task automatic run_payout(input string tag, input int amt, input bit stray);
        bit exp_fault;
        bit fin = 1'b0;
        int clamp;
        int n_exp;
        int n_done = 0;
        int n_ej = 0;
        int cyc = 0;
        int done_cyc = -1;
        plan(amt, exp_fault, clamp);
        n_exp = exp_type_q.size();
        @(negedge clk);
        coin_sum = 6'(amt);
        charge_ind = 1'b1;
        while (!fin && cyc < 400) begin
            @(negedge clk); cyc++;
            if (cyc == 1) begin
                charge_ind = 1'b0;
                chk({tag, "_latch"}, remaining, clamp);
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (eject) begin
                if (n_ej == 0) chk({tag, "_lat"}, cyc, 2);
                n_ej++;
                if (stray && n_ej == 1) charge_ind = 1'b1;
                @(negedge clk); cyc++;
                charge_ind = 1'b0;
                chk({tag, "_hold"}, eject, 1);
                if (exp_type_q.size() == 0) chk({tag, "_extra"}, eject_type, 0);
                else chk({tag, "_type"}, eject_type, exp_type_q.pop_front());
                hopper_ack = 1'b1;
                @(negedge clk); cyc++;
                hopper_ack = stray;
                chk({tag, "_drop"}, eject, 0);
                if (exp_rem_q.size() > 0) chk({tag, "_rem"}, remaining, exp_rem_q.pop_front());
                if (stray) begin
                    @(negedge clk); cyc++;
                    hopper_ack = 1'b0;
                    if (done) n_done++;
                end
            end
            if (fault || (n_done > 0 && !busy)) fin = 1'b1;
        end
        chk({tag, "_finish"}, fin, 1);
        repeat (4) begin
            @(negedge clk);
            if (done) n_done++;
            if (eject) n_ej++;
        end
        chk({tag, "_fault"}, fault, exp_fault);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ncoins"}, n_ej, n_exp);
        chk({tag, "_qleft"}, exp_type_q.size(), 0);
        if (!exp_fault) chk({tag, "_ndone"}, n_done, 1);
        if (amt == 0) chk({tag, "_donelat"}, done_cyc, 2);
    endtask

    initial begin
        int n;
        int cyc;
        model_reset();
        // Reset state
        @(negedge clk);
        chk("rst_eject", eject, 0);
        chk("rst_type", eject_type, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_fault", fault, 0);
        chk("rst_inv", inv_empty, EXP_INV);
        do_reset();

        run_payout("t1", 23, 1'b0);
        do_reset();
        run_payout("t2", 0, 1'b0);
        run_payout("t3", 50, 1'b0);
        do_reset();
        run_payout("t3b", 63, 1'b0);

        // Stray ack while idle, then a payout with a second charge pulse and lingering acks
        do_reset();
        @(negedge clk); hopper_ack = 1'b1;
        @(negedge clk); hopper_ack = 1'b0;
        @(negedge clk);
        chk("t5_idle_ack_busy", busy, 0);
        chk("t5_idle_ack_eject", eject, 0);
        run_payout("t5", 23, 1'b1);

        // Ack withheld: eject held exactly TMO cycles, then sticky fault
        do_reset();
        @(negedge clk);
        coin_sum = 6'd2;
        charge_ind = 1'b1;
        n = 0;
        cyc = 0;
        while (!fault && cyc < 100) begin
            @(negedge clk); cyc++;
            if (cyc == 1) charge_ind = 1'b0;
            if (eject) n++;
        end
        chk("t4_eject_len", n, TMO);
        chk("t4_fault", fault, 1);
        chk("t4_eject", eject, 0);
        chk("t4_busy", busy, 0);
        chk("t4_rem", remaining, 2);
        coin_sum = 6'd0;
        charge_ind = 1'b1;
        @(negedge clk); charge_ind = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy || eject) n++;
        end
        chk("t4_ignored", n, 0);
        chk("t4_sticky", fault, 1);

        // Asynchronous reset while a coin is being ejected
        do_reset();
        @(negedge clk);
        coin_sum = 6'd23;
        charge_ind = 1'b1;
        cyc = 0;
        while (!eject && cyc < 20) begin
            @(negedge clk); cyc++;
            charge_ind = 1'b0;
        end
        chk("t5r_eject_seen", eject, 1);
        rst_n = 1'b0;
        #1;
        chk("t5r_eject", eject, 0);
        chk("t5r_type", eject_type, 0);
        chk("t5r_busy", busy, 0);
        chk("t5r_rem", remaining, 0);
        chk("t5r_fault", fault, 0);
        chk("t5r_inv", inv_empty, EXP_INV);
        do_reset();
        run_payout("t5r_after", 3, 1'b0);

`ifdef CHANGE_INV_EN
        do_reset();
        run_payout("t6a", 20, 1'b0);
        chk("t6a_inv10", inv_empty[0], 1);
        do_reset();
        run_payout("t6b", 1, 1'b0);
        chk("t6b_fault", fault, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
